frame_buffer_arbiter: RTL and testbench
=======================================

FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

Interface
REQ-001 SHALL have parameter mem_width, default 1, frame-buffer pixel data width.
REQ-002 SHALL have parameter mem_addr_width, default 20, frame-buffer address width.
REQ-003 SHALL have parameter fifo_depth, default 4, XL write-FIFO entries; power of two, >= 2.
REQ-004 SHALL have parameter starve_limit, default 8, CPU wait cycles before forced CPU grant; >= 1.
REQ-005 SHALL use a single clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have ports CPU_wr_valid  input  1, CPU_wr_addr  input  mem_addr_width, and CPU_wr_data  input  mem_width: CPU pixel-write request.
REQ-008 SHALL have port CPU_wr_ready  output  1  CPU request accepted this cycle.
REQ-009 SHALL have ports XL_wr_en  input  1, XL_wr_addr  input  mem_addr_width, and XL_wr_data  input  mem_width: line-accelerator write, no backpressure.
REQ-010 SHALL have port XL_full  output  1  XL FIFO full; accelerator pauses.
REQ-011 SHALL have ports FB_wr_en  output  1, FB_wr_addr  output  mem_addr_width, and FB_wr_data  output  mem_width: frame-buffer write.
REQ-012 SHALL have port FB_wr_ready  input  1  frame buffer accepts the write when FB_wr_en and FB_wr_ready are both high.

Function
REQ-013 SHALL hold XL writes in a fifo_depth-entry FIFO with a registered occupancy count of width log2(fifo_depth)+1.
REQ-014 SHALL drive XL_full high exactly when the registered count equals fifo_depth.
REQ-015 SHALL push XL_wr_en when count < fifo_depth, or when count == fifo_depth and a pop occurs in the same cycle; otherwise the write is dropped and FIFO contents are unchanged.
REQ-016 SHALL leave the count unchanged on a simultaneous push and pop, and SHALL wrap read/write pointers modulo fifo_depth.
REQ-017 SHALL hold one output slot whose registered contents drive the FB_wr_en, FB_wr_addr and FB_wr_data outputs.
REQ-018 SHALL treat the slot as free in a cycle when FB_wr_en is low or FB_wr_ready is high.
REQ-019 SHALL choose a source each free cycle by priority: CPU if starve counter == starve_limit and CPU_wr_valid; else FIFO if non-empty; else CPU if CPU_wr_valid; else none.
REQ-020 SHALL, on a free cycle with source none, clear FB_wr_en at the next edge.
REQ-021 SHALL assert CPU_wr_ready combinationally only in a cycle where CPU is the chosen source; it SHALL never be high when the slot is not free.
REQ-022 SHALL pop the FIFO head only in a free cycle where FIFO is the chosen source.
REQ-023 SHALL load the chosen entry into the slot at the clock edge, giving FB_wr_en high the next cycle.
REQ-024 SHALL give CPU a handshake-to-FB_wr_en latency of 1 cycle, and an XL push to an empty FIFO with a free slot an FB_wr_en latency of 2 cycles.
REQ-025 SHALL hold FB_wr_en, FB_wr_addr and FB_wr_data stable while FB_wr_en is high and FB_wr_ready is low.
REQ-026 SHALL increment a starve counter (saturating at starve_limit) each cycle CPU_wr_valid is high and CPU_wr_ready is low.
REQ-027 SHALL clear the starve counter on a CPU handshake or in any cycle CPU_wr_valid is low.
REQ-028 SHALL issue writes to the frame buffer in the exact order XL writes were accepted into the FIFO.

Reset
REQ-029 SHALL, while rst is high at an edge, empty the FIFO (pointers and count = 0), clear the slot (FB_wr_en = 0, FB_wr_addr = 0, FB_wr_data = 0), and zero the starve counter.
REQ-030 SHALL force CPU_wr_ready = 0 while rst is high, and SHALL push nothing while rst is high.
REQ-031 SHALL discard in-flight FIFO entries and the pending slot on reset mid-operation; XL_full = 0 in the first cycle after reset.

Configuration
REQ-032 SHALL, with macro FB_ARB_DROP_COUNT_EN defined, add output XL_drop_cnt, 16 bits, counting XL writes dropped per REQ-015; it saturates at 16'hFFFF and resets to 0.
REQ-033 SHALL, without FB_ARB_DROP_COUNT_EN, have no XL_drop_cnt port or counter; drops remain silent.

Verification
REQ-034 SHALL cover: CPU write addr 0x00010, data 1, FB_wr_ready = 1, FIFO empty -> CPU_wr_ready high the same cycle, FB_wr_en high with addr 0x00010 the next cycle.
REQ-035 SHALL cover: 4 XL writes on consecutive cycles with FB_wr_ready = 0 -> XL_full = 1 after the 4th; a 5th XL write is dropped, and XL_drop_cnt = 1 with the macro defined.
REQ-036 SHALL cover: FIFO continuously refilled and CPU_wr_valid held high -> CPU granted on the cycle its starve counter reaches 8, then the counter returns to 0.
REQ-037 SHALL cover: FB_wr_ready = 0 for 5 cycles with the slot full -> outputs unchanged for 5 cycles, CPU_wr_ready = 0, no FIFO pop.
REQ-038 SHALL cover: full FIFO, FB_wr_ready = 1, XL_wr_en = 1 in the same cycle -> push accepted, count stays 4, no drop.
REQ-039 SHALL cover: rst pulsed high with 3 FIFO entries and a pending slot -> FB_wr_en = 0, XL_full = 0, and no stale write ever appears.

Source files
------------

// File: rtl/frame_buffer_arbiter.sv
// Frame-buffer write arbiter: XL FIFO vs CPU with starvation guard; FB_ARB_DROP_COUNT_EN adds XL_drop_cnt.
// Latency CPU->FB 1 cycle, XL->FB 2 cycles; FB_wr_ready low freezes the slot, stalls CPU, and XL fills then drops.
module frame_buffer_arbiter #(
  parameter int mem_width      = 1,
  parameter int mem_addr_width = 20,
  parameter int fifo_depth     = 4,
  parameter int starve_limit   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      CPU_wr_valid,
  input  logic [mem_addr_width-1:0] CPU_wr_addr,
  input  logic [mem_width-1:0]      CPU_wr_data,
  output logic                      CPU_wr_ready,
  input  logic                      XL_wr_en,
  input  logic [mem_addr_width-1:0] XL_wr_addr,
  input  logic [mem_width-1:0]      XL_wr_data,
  output logic                      XL_full,
  output logic                      FB_wr_en,
  output logic [mem_addr_width-1:0] FB_wr_addr,
  output logic [mem_width-1:0]      FB_wr_data,
  input  logic                      FB_wr_ready
`ifdef FB_ARB_DROP_COUNT_EN
  , output logic [15:0]             XL_drop_cnt
`endif
);

  localparam int PW = $clog2(fifo_depth);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(starve_limit + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth);
  localparam logic [SW-1:0] LIMIT_C = SW'(starve_limit);

  logic [mem_addr_width-1:0] fifo_addr_q [fifo_depth];
  logic [mem_width-1:0]      fifo_data_q [fifo_depth];
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic [SW-1:0]             starve_q, starve_d;
  logic                      slot_vld_q, slot_vld_d;
  logic [mem_addr_width-1:0] slot_addr_q, slot_addr_d;
  logic [mem_width-1:0]      slot_data_q, slot_data_d;

  logic slot_free, fifo_empty, starved, sel_cpu, sel_fifo, push;

  assign slot_free  = !slot_vld_q || FB_wr_ready;
  assign fifo_empty = (count_q == '0);
  assign starved    = (starve_q == LIMIT_C);

  always_comb begin
    sel_cpu  = 1'b0;
    sel_fifo = 1'b0;
    if (!rst && slot_free) begin
      if (CPU_wr_valid && starved) sel_cpu = 1'b1;
      else if (!fifo_empty)        sel_fifo = 1'b1;
      else if (CPU_wr_valid)       sel_cpu = 1'b1;
    end
  end

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push = XL_wr_en && !rst && ((count_q != DEPTH_C) || sel_fifo);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push)     wr_ptr_d = wr_ptr_q + PW'(1);
    if (sel_fifo) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !sel_fifo)      count_d = count_q + CW'(1);
    else if (!push && sel_fifo) count_d = count_q - CW'(1);
  end

  always_comb begin
    slot_vld_d  = slot_vld_q;
    slot_addr_d = slot_addr_q;
    slot_data_d = slot_data_q;
    if (sel_cpu) begin
      slot_vld_d  = 1'b1;
      slot_addr_d = CPU_wr_addr;
      slot_data_d = CPU_wr_data;
    end else if (sel_fifo) begin
      slot_vld_d  = 1'b1;
      slot_addr_d = fifo_addr_q[rd_ptr_q];
      slot_data_d = fifo_data_q[rd_ptr_q];
    end else if (slot_free) begin
      slot_vld_d  = 1'b0;
    end
  end

  always_comb begin
    starve_d = '0;
    if (CPU_wr_valid && !sel_cpu) starve_d = starved ? starve_q : starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      slot_vld_q  <= 1'b0;
      slot_addr_q <= '0;
      slot_data_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      slot_vld_q  <= slot_vld_d;
      slot_addr_q <= slot_addr_d;
      slot_data_q <= slot_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= XL_wr_addr;
      fifo_data_q[wr_ptr_q] <= XL_wr_data;
    end
  end

`ifdef FB_ARB_DROP_COUNT_EN
  logic        drop;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  assign drop = XL_wr_en && !rst && !push;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign XL_drop_cnt = drop_cnt_q;
`endif

  assign CPU_wr_ready = sel_cpu;
  assign XL_full      = (count_q == DEPTH_C);
  assign FB_wr_en     = slot_vld_q;
  assign FB_wr_addr   = slot_addr_q;
  assign FB_wr_data   = slot_data_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Bench for frame_buffer_arbiter: queue-based reference model checked every cycle, plus directed literal checks.
module tb_frame_buffer_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        CPU_wr_valid;
  logic [19:0] CPU_wr_addr;
  logic [0:0]  CPU_wr_data;
  logic        CPU_wr_ready;
  logic        XL_wr_en;
  logic [19:0] XL_wr_addr;
  logic [0:0]  XL_wr_data;
  logic        XL_full;
  logic        FB_wr_en;
  logic [19:0] FB_wr_addr;
  logic [0:0]  FB_wr_data;
  logic        FB_wr_ready;
`ifdef FB_ARB_DROP_COUNT_EN
  logic [15:0] XL_drop_cnt;
`endif

  frame_buffer_arbiter #(
    .mem_width(1), .mem_addr_width(20), .fifo_depth(DEPTH), .starve_limit(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .CPU_wr_valid(CPU_wr_valid), .CPU_wr_addr(CPU_wr_addr), .CPU_wr_data(CPU_wr_data),
    .CPU_wr_ready(CPU_wr_ready),
    .XL_wr_en(XL_wr_en), .XL_wr_addr(XL_wr_addr), .XL_wr_data(XL_wr_data), .XL_full(XL_full),
    .FB_wr_en(FB_wr_en), .FB_wr_addr(FB_wr_addr), .FB_wr_data(FB_wr_data),
    .FB_wr_ready(FB_wr_ready)
`ifdef FB_ARB_DROP_COUNT_EN
    , .XL_drop_cnt(XL_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: accepted XL writes as a queue, the output slot, the CPU wait count.
  logic [20:0] fq[$];
  logic        m_vld = 1'b0;
  logic [19:0] m_addr = '0;
  logic        m_data = 1'b0;
  int          m_starve = 0;
  int          m_drops = 0;
  bit          started = 1'b0;

  function automatic bit cpu_wins(input bit free);
    return free && CPU_wr_valid && ((m_starve == LIMIT) || (fq.size() == 0));
  endfunction

  always @(posedge clk) begin
    bit          free, g_cpu;
    logic [20:0] e;
    if (rst) begin
      fq.delete();
      m_vld = 1'b0; m_addr = '0; m_data = 1'b0;
      m_starve = 0; m_drops = 0;
      started = 1'b1;
    end else begin
      free  = !m_vld || FB_wr_ready;
      g_cpu = cpu_wins(free);
      if (g_cpu) begin
        m_vld = 1'b1; m_addr = CPU_wr_addr; m_data = CPU_wr_data[0];
      end else if (free && fq.size() > 0) begin
        e = fq.pop_front();
        m_vld = 1'b1; m_addr = e[20:1]; m_data = e[0];
      end else if (free) begin
        m_vld = 1'b0;
      end
      if (XL_wr_en) begin
        if (fq.size() < DEPTH) fq.push_back({XL_wr_addr, XL_wr_data[0]});
        else if (m_drops < 65535) m_drops++;
      end
      if (CPU_wr_valid && !g_cpu) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else m_starve = 0;
    end
  end

  always @(negedge clk) begin
    bit e_ready;
    if (started) begin
      e_ready = !rst && cpu_wins(!m_vld || FB_wr_ready);
      chk("m_cpu_ready", 32'(CPU_wr_ready), 32'(e_ready));
      chk("m_xl_full",   32'(XL_full),      32'(fq.size() == DEPTH));
      chk("m_fb_en",     32'(FB_wr_en),     32'(m_vld));
      chk("m_fb_addr",   32'(FB_wr_addr),   32'(m_addr));
      chk("m_fb_data",   32'(FB_wr_data),   32'(m_data));
`ifdef FB_ARB_DROP_COUNT_EN
      chk("m_drop_cnt",  32'(XL_drop_cnt),  32'(m_drops));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic idle_inputs();
    CPU_wr_valid = 1'b0; CPU_wr_addr = '0; CPU_wr_data = '0;
    XL_wr_en = 1'b0; XL_wr_addr = '0; XL_wr_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with requests asserted: nothing granted, nothing pushed.
    rst = 1'b1; FB_wr_ready = 1'b1;
    CPU_wr_valid = 1'b1; CPU_wr_addr = 20'h00077; CPU_wr_data = 1'b1;
    XL_wr_en = 1'b1; XL_wr_addr = 20'h00088; XL_wr_data = 1'b1;
    cyc();
    mid();
    chk("rst_cpu_ready", 32'(CPU_wr_ready), 32'd0);
    chk("rst_fb_en",     32'(FB_wr_en),     32'd0);
    chk("rst_xl_full",   32'(XL_full),      32'd0);
    chk("rst_fb_addr",   32'(FB_wr_addr),   32'd0);
    cyc();
    rst = 1'b0; idle_inputs();
    mid();
    chk("post_rst_fb_en", 32'(FB_wr_en), 32'd0);
    cyc();

    // Single CPU write, 1-cycle latency.
    CPU_wr_valid = 1'b1; CPU_wr_addr = 20'h00010; CPU_wr_data = 1'b1;
    mid();
    chk("cpu1_ready", 32'(CPU_wr_ready), 32'd1);
    chk("cpu1_en0",   32'(FB_wr_en),     32'd0);
    cyc();
    CPU_wr_valid = 1'b0;
    mid();
    chk("cpu1_en",   32'(FB_wr_en),   32'd1);
    chk("cpu1_addr", 32'(FB_wr_addr), 32'h00010);
    chk("cpu1_data", 32'(FB_wr_data), 32'd1);
    cyc();
    mid();
    chk("cpu1_idle", 32'(FB_wr_en), 32'd0);

    // Stalled slot, then fill the FIFO and overflow it by one.
    FB_wr_ready = 1'b0;
    CPU_wr_valid = 1'b1; CPU_wr_addr = 20'h00020; CPU_wr_data = 1'b0;
    cyc();
    CPU_wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      XL_wr_en = 1'b1; XL_wr_addr = 20'h00100 + 20'(i); XL_wr_data = 1'(i[0]);
      cyc();
    end
    XL_wr_en = 1'b1; XL_wr_addr = 20'h001FF; XL_wr_data = 1'b1;
    mid();
    chk("fill_full", 32'(XL_full), 32'd1);
    cyc();
    XL_wr_en = 1'b0;
`ifdef FB_ARB_DROP_COUNT_EN
    mid();
    chk("drop_cnt_1", 32'(XL_drop_cnt), 32'd1);
`endif

    // Five stalled cycles: slot frozen, CPU held off, no pop.
    CPU_wr_valid = 1'b1; CPU_wr_addr = 20'h00030; CPU_wr_data = 1'b1;
    for (int s = 0; s < 5; s++) begin
      mid();
      chk("stall_ready", 32'(CPU_wr_ready), 32'd0);
      chk("stall_en",    32'(FB_wr_en),     32'd1);
      chk("stall_addr",  32'(FB_wr_addr),   32'h00020);
      chk("stall_full",  32'(XL_full),      32'd1);
      cyc();
    end

    // Full FIFO with a pop in the same cycle accepts the push.
    CPU_wr_valid = 1'b0; FB_wr_ready = 1'b1;
    XL_wr_en = 1'b1; XL_wr_addr = 20'h00104; XL_wr_data = 1'b0;
    mid();
    chk("pp_ready", 32'(CPU_wr_ready), 32'd0);
    cyc();
    XL_wr_en = 1'b0;
    mid();
    chk("pp_head", 32'(FB_wr_addr), 32'h00100);
    chk("pp_full", 32'(XL_full),    32'd1);
`ifdef FB_ARB_DROP_COUNT_EN
    chk("pp_nodrop", 32'(XL_drop_cnt), 32'd1);
`endif
    cyc();
    for (int j = 1; j <= 4; j++) begin
      mid();
      chk("order_en",   32'(FB_wr_en),   32'd1);
      chk("order_addr", 32'(FB_wr_addr), 32'h00100 + 32'(j));
      cyc();
    end
    mid();
    chk("drain_idle", 32'(FB_wr_en), 32'd0);

    // Starvation: FIFO kept non-empty, CPU wins once its wait count reaches the limit.
    XL_wr_en = 1'b1; XL_wr_addr = 20'h00200; XL_wr_data = 1'b1;
    cyc();
    for (int k = 1; k <= 10; k++) begin
      XL_wr_addr = 20'h00200 + 20'(k); XL_wr_data = 1'(k[0]);
      CPU_wr_valid = 1'b1; CPU_wr_addr = 20'h00040; CPU_wr_data = 1'b1;
      mid();
      chk("starve_ready", 32'(CPU_wr_ready), 32'(k == 9));
      if (k == 1) chk("xl_lat_en0", 32'(FB_wr_en), 32'd0);
      if (k == 2) begin
        chk("xl_lat_en",   32'(FB_wr_en),   32'd1);
        chk("xl_lat_addr", 32'(FB_wr_addr), 32'h00200);
      end
      if (k == 10) chk("starve_grant_addr", 32'(FB_wr_addr), 32'h00040);
      cyc();
    end
    idle_inputs();
    repeat (5) cyc();

    // Reset mid-operation with a pending slot and three queued entries.
    FB_wr_ready = 1'b0;
    CPU_wr_valid = 1'b1; CPU_wr_addr = 20'h00050; CPU_wr_data = 1'b1;
    cyc();
    CPU_wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      XL_wr_en = 1'b1; XL_wr_addr = 20'h00300 + 20'(i); XL_wr_data = 1'b1;
      cyc();
    end
    rst = 1'b1;
    XL_wr_en = 1'b1; XL_wr_addr = 20'h003FF;
    CPU_wr_valid = 1'b1; CPU_wr_addr = 20'h00060;
    mid();
    chk("mrst_ready", 32'(CPU_wr_ready), 32'd0);
    cyc();
    rst = 1'b0; idle_inputs(); FB_wr_ready = 1'b1;
    mid();
    chk("mrst_en",   32'(FB_wr_en),   32'd0);
    chk("mrst_full", 32'(XL_full),    32'd0);
    chk("mrst_addr", 32'(FB_wr_addr), 32'd0);
    for (int s = 0; s < 6; s++) begin
      cyc();
      mid();
      chk("mrst_no_stale", 32'(FB_wr_en), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
